snake_round_ctrl: RTL and testbench

Game-round controller for the snake datapath. Runs the IDLE → RUN → PAUSED → OVER round state machine and generates the single-cycle game tick that steps the movement, tracking and collision logic. Samples collision, item-pickup and length feedback from that datapath. Keeps the score and speeds the tick up as items are eaten. Sits between the board buttons, the `SYS_CLK` domain and the snake datapath modules; it replaces a free-running game clock.

---
 rtl/snake_round_ctrl_if.sv | 26 ++
 rtl/snake_round_ctrl.sv | 171 +++++++++++++++++
 tb/tb_snake_round_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/snake_round_ctrl_if.sv
// Button, datapath-feedback and round-status bundle for snake_round_ctrl.
// slave = the controller; master = the board/datapath side driving buttons and feedback.
interface snake_round_ctrl_if;
    logic       START;
    logic       PAUSE;
    logic       COLLISION;
    logic       GOT_ITEM;
    logic [7:0] LENGTH;
    logic       TICK;
    logic       GAME_RST;
    logic [1:0] STATE;
    logic       ISPAUSED;
    logic [7:0] SCORE;
    logic       GAME_OVER;
    logic       WIN;

    modport master (
        output START, PAUSE, COLLISION, GOT_ITEM, LENGTH,
        input  TICK, GAME_RST, STATE, ISPAUSED, SCORE, GAME_OVER, WIN
    );

    modport slave (
        input  START, PAUSE, COLLISION, GOT_ITEM, LENGTH,
        output TICK, GAME_RST, STATE, ISPAUSED, SCORE, GAME_OVER, WIN
    );
endinterface

// File: rtl/snake_round_ctrl.sv
// Snake round FSM + game tick generator; define SNAKE_SPEEDUP_EN to shorten the tick period per item.
// Latency: all outputs registered, 1 cycle from button rise or EVAL; no backpressure (strobes and levels only).
module snake_round_ctrl #(
    parameter int TICK_DIV     = 100,
    parameter int SPEEDUP_STEP = 8,
    parameter int MIN_DIV      = 20,
    parameter int WIN_LENGTH   = 255
) (
    input  logic               SYS_CLK,
    input  logic               RST,
    snake_round_ctrl_if.slave  bus
);

    localparam int CW = $clog2(TICK_DIV + 1);
    localparam logic [CW-1:0] TICK_DIV_C = CW'(TICK_DIV);
    localparam logic [7:0]    WIN_LEN_C  = 8'(WIN_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    if (TICK_DIV < 4 || MIN_DIV < 4 || MIN_DIV > TICK_DIV || SPEEDUP_STEP < 0 ||
        WIN_LENGTH < 1 || WIN_LENGTH > 255) begin : g_bad_cfg
        $error("snake_round_ctrl: illegal parameter combination");
    end

`ifdef SNAKE_SPEEDUP_EN
    // Compared in int so a step larger than the period never wraps.
    function automatic logic [CW-1:0] next_period(input logic [CW-1:0] p);
        if (int'(p) >= MIN_DIV + SPEEDUP_STEP)
            return p - CW'(SPEEDUP_STEP);
        else
            return CW'(MIN_DIV);
    endfunction
`endif

    state_t        state_d, state_q;
    logic          start_d, start_q;
    logic          pause_d, pause_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [CW-1:0] period_d, period_q;
    logic          tick_d, tick_q;
    logic          game_rst_d, game_rst_q;
    logic          ispaused_d, ispaused_q;
    logic          game_over_d, game_over_q;
    logic          win_d, win_q;
    logic [7:0]    score_d, score_q;

    logic start_rise;
    logic pause_rise;
    logic eval_over;

    assign start_rise = bus.START & ~start_q;
    assign pause_rise = bus.PAUSE & ~pause_q;

    always_comb begin
        state_d   = state_q;
        start_d   = bus.START;
        pause_d   = bus.PAUSE;
        cnt_d     = cnt_q;
        period_d  = period_q;
        score_d   = score_q;
        win_d     = win_q;
        tick_d    = 1'b0;
        eval_over = 1'b0;

        if (state_q == ST_RUN) begin
            if (cnt_q == '0) begin
                cnt_d  = period_q - CW'(1);
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        // EVAL is the cycle after TICK; it still fires if PAUSED was entered on the TICK edge.
        if (tick_q) begin
            if (bus.COLLISION) begin
                state_d   = ST_OVER;
                win_d     = 1'b0;
                eval_over = 1'b1;
            end else if (bus.LENGTH >= WIN_LEN_C) begin
                state_d   = ST_OVER;
                win_d     = 1'b1;
                eval_over = 1'b1;
            end else if (bus.GOT_ITEM) begin
                if (score_q != 8'hFF)
                    score_d = score_q + 8'd1;
`ifdef SNAKE_SPEEDUP_EN
                period_d = next_period(period_q);
`endif
            end
        end

        if (!eval_over) begin
            case (state_q)
                ST_IDLE: begin
                    period_d = TICK_DIV_C;
                    score_d  = 8'd0;
                    win_d    = 1'b0;
                    cnt_d    = '0;
                    if (start_rise) begin
                        state_d = ST_RUN;
                        cnt_d   = TICK_DIV_C - CW'(1);
                    end
                end
                ST_RUN: begin
                    if (pause_rise)
                        state_d = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (pause_rise)
                        state_d = ST_RUN;
                end
                ST_OVER: begin
                    if (start_rise) begin
                        state_d  = ST_IDLE;
                        score_d  = 8'd0;
                        win_d    = 1'b0;
                        period_d = TICK_DIV_C;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        game_rst_d  = (state_d == ST_IDLE);
        ispaused_d  = (state_d == ST_PAUSED);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            cnt_q       <= '0;
            period_q    <= TICK_DIV_C;
            tick_q      <= 1'b0;
            game_rst_q  <= 1'b1;
            ispaused_q  <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            score_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            pause_q     <= pause_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            tick_q      <= tick_d;
            game_rst_q  <= game_rst_d;
            ispaused_q  <= ispaused_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
            score_q     <= score_d;
        end
    end

    assign bus.TICK      = tick_q;
    assign bus.GAME_RST  = game_rst_q;
    assign bus.STATE     = state_q;
    assign bus.ISPAUSED  = ispaused_q;
    assign bus.SCORE     = score_q;
    assign bus.GAME_OVER = game_over_q;
    assign bus.WIN       = win_q;

endmodule

// File: tb/tb_snake_round_ctrl.sv
// Random-stimulus bench for snake_round_ctrl against an event-time reference model.
module tb_snake_round_ctrl;

    localparam int TICK_DIV = 10;
    localparam int STEP     = 2;
    localparam int MIN_DIV  = 4;
    localparam int WIN_LEN  = 8;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_OVER = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_round_ctrl_if bus ();

    snake_round_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .SPEEDUP_STEP (STEP),
        .MIN_DIV      (MIN_DIV),
        .WIN_LENGTH   (WIN_LEN)
    ) dut (
        .SYS_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: tracks the absolute cycle of the next tick rather than a counter.
    int n = 0;
    int m_state, m_score, m_period, m_tick_at, m_rem;
    bit m_win, exp_tick, last_tick, prev_start, prev_pause;
    bit start_l, pause_l;
    bit tick_rst_done = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = M_IDLE;
        m_score    = 0;
        m_win      = 0;
        m_period   = TICK_DIV;
        m_tick_at  = 0;
        m_rem      = 0;
        exp_tick   = 0;
        last_tick  = 0;
        prev_start = 0;
        prev_pause = 0;
    endtask

    task automatic model_step();
        bit s_rise, p_rise, over_now;
        n++;
        s_rise     = bus.START && !prev_start;
        p_rise     = bus.PAUSE && !prev_pause;
        prev_start = bus.START;
        prev_pause = bus.PAUSE;
        over_now   = 0;
        exp_tick   = 0;
        if (m_state == M_RUN && n == m_tick_at) begin
            exp_tick  = 1;
            m_tick_at = n + m_period;
        end
        if (last_tick) begin
            if (bus.COLLISION) begin
                m_state = M_OVER; m_win = 0; over_now = 1;
            end else if (int'(bus.LENGTH) >= WIN_LEN) begin
                m_state = M_OVER; m_win = 1; over_now = 1;
            end else if (bus.GOT_ITEM) begin
                if (m_score < 255) m_score++;
`ifdef SNAKE_SPEEDUP_EN
                m_period = (m_period - STEP < MIN_DIV) ? MIN_DIV : m_period - STEP;
`endif
            end
        end
        if (!over_now) begin
            case (m_state)
                M_IDLE:   if (s_rise) begin m_state = M_RUN; m_tick_at = n + m_period; end
                M_RUN:    if (p_rise) begin m_state = M_PAUSED; m_rem = m_tick_at - n; end
                M_PAUSED: if (p_rise) begin m_state = M_RUN; m_tick_at = n + m_rem; end
                default:  if (s_rise) begin
                              m_state = M_IDLE; m_score = 0; m_win = 0; m_period = TICK_DIV;
                          end
            endcase
        end
        last_tick = exp_tick;
    endtask

    task automatic check_outputs();
        chk("state",     32'(bus.STATE),     32'(m_state));
        chk("tick",      32'(bus.TICK),      32'(exp_tick));
        chk("game_rst",  32'(bus.GAME_RST),  32'(m_state == M_IDLE));
        chk("ispaused",  32'(bus.ISPAUSED),  32'(m_state == M_PAUSED));
        chk("game_over", 32'(bus.GAME_OVER), 32'(m_state == M_OVER));
        chk("score",     32'(bus.SCORE),     32'(m_score));
        chk("win",       32'(bus.WIN),       32'(m_win));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"},     32'(bus.STATE),     0);
        chk({tag, "_tick"},      32'(bus.TICK),      0);
        chk({tag, "_game_rst"},  32'(bus.GAME_RST),  1);
        chk({tag, "_ispaused"},  32'(bus.ISPAUSED),  0);
        chk({tag, "_score"},     32'(bus.SCORE),     0);
        chk({tag, "_game_over"}, 32'(bus.GAME_OVER), 0);
        chk({tag, "_win"},       32'(bus.WIN),       0);
    endtask

    task automatic drive_inputs(input int mode);
        if ($urandom_range(0, 7) == 0) start_l = ~start_l;
        if (mode == 0) begin
            if ($urandom_range(0, 29) == 0) pause_l = ~pause_l;
        end else begin
            if ($urandom_range(0, 199) == 0) pause_l = ~pause_l;
        end
        bus.START     = start_l;
        bus.PAUSE     = pause_l;
        bus.COLLISION = (mode == 0) && ($urandom_range(0, 14) == 0);
        bus.GOT_ITEM  = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.LENGTH    = (mode == 0 && $urandom_range(0, 19) == 0) ? 8'($urandom_range(8, 255))
                                                                  : 8'($urandom_range(0, 7));
    endtask

    // Asserts RST mid-cycle (between edges) and checks outputs drop without waiting for a clock.
    task automatic async_reset();
        #1 rst = 1'b1;
        #1 check_reset_vals("arst");
        model_reset();
        @(posedge clk);
        #1 chk("arst_hold_tick", 32'(bus.TICK), 0);
        chk("arst_hold_state", 32'(bus.STATE), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered at a negedge; leaves at a negedge.
    task automatic run_phase(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            drive_inputs(mode);
            @(posedge clk);
            model_step();
            #1 check_outputs();
            if (mode == 0 && !tick_rst_done && n > 200 && m_state == M_RUN && m_tick_at == n + 1) begin
                tick_rst_done = 1;
                async_reset();
            end else if (mode == 0 && $urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        start_l       = 0;
        pause_l       = 0;
        bus.START     = 1'b0;
        bus.PAUSE     = 1'b0;
        bus.COLLISION = 1'b0;
        bus.GOT_ITEM  = 1'b0;
        bus.LENGTH    = 8'd0;
        model_reset();
        #12 check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;

        run_phase(2500, 0);
        run_phase(3500, 1);
        run_phase(500, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
